// File: rtl/alu_pkg.sv
// Shared ALU operation codes and FSM state encoding for the serial ALU and the ALU decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_BEQ = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Operations that subtract: B is inverted and the carry chain starts at 1.
  function automatic logic is_inv(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_BEQ) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide ALU slice: add/sub with carry, bitwise and/or, plus msbs for overflow.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  input  logic             inv,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb,
  output logic             s_msb
);

  logic [DIGIT:0] sum;

  always_comb begin
    sum   = {1'b0, a_d} + {1'b0, b_d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
    cout  = sum[DIGIT];
    s_msb = sum[DIGIT-1];
    a_msb = a_d[DIGIT-1];
    b_msb = b_d[DIGIT-1];
    case (op)
      ALU_AND: y = a_d & b_d;
      ALU_OR:  y = a_d | b_d;
      default: y = sum[DIGIT-1:0];
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: accepts one operation per handshake, processes DIGIT bits per cycle,
// and returns result plus zero flag on a second valid/ready handshake.
module serial_alu
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DIGIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int NDIG = XLEN / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((DIGIT < 1) || ((XLEN % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_alu: DIGIT must be >= 1 and divide XLEN");
    end
  endgenerate

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic            carry;
  logic [XLEN-1:0] a_sh, b_sh, res_sh;
  logic [2:0]      op_q;
  logic            zero_q;

  logic [DIGIT-1:0] dig_y;
  logic             dig_cout, a_msb, b_msb, s_msb;
  logic [XLEN-1:0]  shifted, final_res;
  logic             lt, last;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (a_sh[DIGIT-1:0]),
    .b_d   (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .inv   (is_inv(op_q)),
    .op    (op_q),
    .y     (dig_y),
    .cout  (dig_cout),
    .a_msb (a_msb),
    .b_msb (b_msb),
    .s_msb (s_msb)
  );

  // Each digit enters at the top so after NDIG cycles the result is aligned.
  generate
    if (DIGIT == XLEN) begin : g_single
      assign shifted = dig_y;
    end else begin : g_multi
      assign shifted = {dig_y, res_sh[XLEN-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    last = (count == LAST);
    lt   = s_msb ^ ((a_msb != b_msb) && (s_msb != a_msb));
    case (op_q)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_BEQ: final_res = shifted;
      ALU_SLT: final_res = {{(XLEN-1){1'b0}}, lt};
      default: final_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_RUN;
      end
      S_RUN: begin
        if (last) next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= '0;
      zero_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= alu_op;
            count <= '0;
            carry <= is_inv(alu_op);
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dig_cout;
          count <= count + 1'b1;
          if (last) begin
            res_sh <= final_res;
            zero_q <= (final_res == '0);
          end else begin
            res_sh <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res_sh;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (XLEN=32, DIGIT=8).
module tb_serial_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_alu #(.XLEN(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns latency (edges after accept until out_valid), result, zero.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit release_out, output int lat, output logic [31:0] res,
                        output logic z);
    int w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    alu_op = op; a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~av; b = ~bv; alu_op = ~op;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    res = result;
    z = zero;
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero got=%b exp=1", zero); else pass_cnt++;
  endtask

  task automatic test_add();
    int lat; logic [31:0] r; logic z; int w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    alu_op = ALU_ADD; a = 32'd5; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '1; b = '1;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    total_cnt++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL add_in_ready_done got=%b exp=0", in_ready); else pass_cnt++;
    r = result; z = zero;
    total_cnt++; if (r !== 32'h0000000C) $display("FAIL add_result got=%h exp=0000000c", r); else pass_cnt++;
    total_cnt++; if (z !== 1'b0) $display("FAIL add_zero got=%b exp=0", z); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL add_release got=%b%b exp=10", in_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_sub();
    int lat; logic [31:0] r; logic z;
    run_op(ALU_SUB, 32'd3, 32'd5, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'hFFFFFFFE || z !== 1'b0)
      $display("FAIL sub_3_5 lat=%0d res=%h z=%b exp lat=4 res=fffffffe z=0", lat, r, z); else pass_cnt++;
    run_op(ALU_SUB, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h0 || z !== 1'b1)
      $display("FAIL sub_equal lat=%0d res=%h z=%b exp lat=4 res=0 z=1", lat, r, z); else pass_cnt++;
  endtask

  task automatic test_slt();
    int lat; logic [31:0] r; logic z;
    run_op(ALU_SLT, 32'h80000000, 32'h1, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h1 || z !== 1'b0)
      $display("FAIL slt_min_1 lat=%0d res=%h z=%b exp lat=4 res=1 z=0", lat, r, z); else pass_cnt++;
    run_op(ALU_SLT, 32'h1, 32'h80000000, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h0 || z !== 1'b1)
      $display("FAIL slt_1_min lat=%0d res=%h z=%b exp lat=4 res=0 z=1", lat, r, z); else pass_cnt++;
    run_op(ALU_SLT, 32'hFFFFFFFF, 32'h0, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h1 || z !== 1'b0)
      $display("FAIL slt_m1_0 lat=%0d res=%h z=%b exp lat=4 res=1 z=0", lat, r, z); else pass_cnt++;
  endtask

  task automatic test_logic_beq();
    int lat; logic [31:0] r; logic z;
    run_op(ALU_BEQ, 32'h1234, 32'h1234, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h0 || z !== 1'b1)
      $display("FAIL beq_equal lat=%0d res=%h z=%b exp lat=4 res=0 z=1", lat, r, z); else pass_cnt++;
    run_op(ALU_BEQ, 32'h1234, 32'h1235, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'hFFFFFFFF || z !== 1'b0)
      $display("FAIL beq_differ lat=%0d res=%h z=%b exp lat=4 res=ffffffff z=0", lat, r, z); else pass_cnt++;
    run_op(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'hF000F000 || z !== 1'b0)
      $display("FAIL and_op lat=%0d res=%h z=%b exp lat=4 res=f000f000 z=0", lat, r, z); else pass_cnt++;
    run_op(ALU_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'hFFF0FFF0 || z !== 1'b0)
      $display("FAIL or_op lat=%0d res=%h z=%b exp lat=4 res=fff0fff0 z=0", lat, r, z); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic z;
    run_op(ALU_ADD, 32'd1, 32'd2, 1'b0, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'd3) $display("FAIL bp_first lat=%0d res=%h exp lat=4 res=3", lat, r); else pass_cnt++;
    // New request presented while the result is held.
    alu_op = ALU_SUB; a = 32'd10; b = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (result !== 32'd3 || zero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d res=%h z=%b ov=%b ir=%b exp res=3 z=0 ov=1 ir=0",
                 i, result, zero, out_valid, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_accept ir=%b exp 0", in_ready); else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    total_cnt++; if (lat !== 4 || result !== 32'd6 || zero !== 1'b0)
      $display("FAIL bp_second lat=%0d res=%h z=%b exp lat=4 res=6 z=0", lat, result, zero); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc0 = -100, acc1 = -100, nacc = 0, ov_cnt = 0, w = 0;
    alu_op = ALU_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) begin
        if (nacc == 0) acc0 = i; else if (nacc == 1) acc1 = i;
        nacc++;
      end
      if (out_valid) ov_cnt++;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (acc1 - acc0 !== 6) $display("FAIL b2b_interval got=%0d exp=6", acc1 - acc0); else pass_cnt++;
    total_cnt++; if (ov_cnt !== 2) $display("FAIL b2b_out_valid_cycles got=%0d exp=2", ov_cnt); else pass_cnt++;
    while (!in_ready && w < 20) begin tick(); w++; end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat, seen = 0, w = 0; logic [31:0] r; logic z;
    while (!in_ready && w < 20) begin tick(); w++; end
    alu_op = ALU_SUB; a = 32'd9; b = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1)
      $display("FAIL midrun_reset ir=%b ov=%b res=%h z=%b exp ir=1 ov=0 res=0 z=1",
               in_ready, out_valid, result, zero); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total_cnt++; if (seen !== 0) $display("FAIL midrun_late_valid got=%0d exp=0", seen); else pass_cnt++;
    run_op(3'b110, 32'd5, 32'd7, 1'b1, lat, r, z);
    total_cnt++; if (lat !== 4 || r !== 32'h0 || z !== 1'b1)
      $display("FAIL reserved_op lat=%0d res=%h z=%b exp lat=4 res=0 z=1", lat, r, z); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic_beq();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
